bus_serializer: RTL and testbench
=================================

Name: bus_serializer

Overview:
- Parallel-to-bus transmitter, the counterpart of the bus-to-shift-register input loader.
- Takes an n*s-bit vector, such as the concatenated layer outputs, and drives it one n-bit word per cycle onto the shared tri-state bus.
- Generates the matching RAM address and write strobes, so a batch of vectors is stored word-by-word in node/result RAM.
- Sits between the datapath (ai_top / backprop) and the shared bus; the control unit starts it and watches done.

Parameters:
- n, `n (fixed_point.vh), word width in bits.
- s, 2, words per vector (vector width n*s).
- a, 32, RAM address width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a batch; sampled only in IDLE.
- count  input  n  number of vectors in the batch; captured on start.
- base_addr  input  a  first RAM word address; captured on start.
- din  input  n*s  vector to send; word k is din[n*k +: n]; word 0 (LSB) is sent first.
- vec_valid  input  1  din holds a valid vector.
- vec_ready  output  1  serializer will accept din this cycle.
- bus_out  output  n  word to drive onto the bus.
- bus_en  output  1  tri-state enable; top level implements bus = bus_en ? bus_out : 'z.
- addr  output  a  RAM address for the current word.
- we  output  8  RAM byte write enables; 8'hFF while a word is driven, else 0.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at end of batch.

Behaviour:
- Reset, asynchronous: state=IDLE, shift register=0, pointer=0, vector counter=0, word counter=0. All outputs 0, effective immediately, including mid-operation.
- States: IDLE, WAIT, SHIFT, DONE.
- IDLE, on start:
  - Latch count into vcnt and base_addr into ptr.
  - If count==0, go to DONE; otherwise go to WAIT.
  - start in any other state is ignored and does not alter latched values.
- WAIT:
  - vec_ready=1; bus_en=0; we=0.
  - On vec_valid & vec_ready at the edge: load din into the shift register, set wcnt=0, go to SHIFT.
  - If vec_valid is low, stay in WAIT indefinitely.
- SHIFT, each cycle:
  - Drive bus_en=1, bus_out=sreg[n-1:0], addr=ptr, we=8'hFF.
  - At the edge: sreg shifts right by n (zero-fill), ptr=ptr+1 mod 2^a, wcnt=wcnt+1.
  - On the edge where wcnt reaches s-1: decrement vcnt. If the result is 0, go to DONE; otherwise go to WAIT.
  - Exactly s bus cycles per vector. vec_ready=0 throughout.
- DONE: done=1 for one cycle, bus_en=0, then IDLE.
- Timing:
  - Latency from accepting a vector to its first word on the bus is 1 cycle.
  - Back-to-back vectors cost s+1 cycles each, because WAIT takes one cycle.
- bus_en is never high outside SHIFT, so there is no bus contention with other drivers.
- addr and we are only meaningful while bus_en=1; otherwise addr holds ptr and we=0.
- Width rules:
  - vcnt is n bits unsigned; count is treated as unsigned.
  - ptr wraps modulo 2^a without error.
- Outputs are decoded from registered state only (Moore); there is no combinational path from din or vec_valid to outputs other than vec_ready, which depends on state only.

Test Plan:
- Reset check: assert rst mid-SHIFT, with bus_en=1 and we=FF. Outputs 0 asynchronously before the next edge; after release, state is IDLE and busy=0.
- Single vector (n=16, s=2): start, count=1, base_addr=0x10, din=0x0002_0001, vec_valid=1. Expected:
  - vec_ready for 1 cycle.
  - Next cycle: bus_out=0x0001, addr=0x10, we=FF.
  - Then bus_out=0x0002, addr=0x11.
  - Then done=1 for 1 cycle; busy falls.
- Batch with stalls: count=3; vec_valid low for 2 cycles before each vector. Expected:
  - bus_en=0 during each stall.
  - Exactly 6 writes to addresses 0x10..0x15 in word order.
  - A single done pulse after the last write.
- Zero count: start with count=0. Expected: done one cycle after start, we never asserted, vec_ready never asserted.
- Start while busy: pulse start with count=5, base_addr=0x80 during SHIFT of a count=1 batch. Expected: ignored; the original batch completes with its original addresses, then IDLE.
- Address wrap: base_addr=0xFFFFFFFF, count=1. Expected: words written at 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/bus_serializer_if.sv
// Handshake and bus signals between the datapath/control side and bus_serializer.
// master: control unit / datapath that starts batches and supplies vectors.
// slave:  the serializer itself.
interface bus_serializer_if #(
  parameter int unsigned N = 16,  // word width
  parameter int unsigned S = 2,   // words per vector
  parameter int unsigned A = 32   // RAM address width
);
  logic             start;
  logic [N-1:0]     count;
  logic [A-1:0]     base_addr;
  logic [N*S-1:0]   din;
  logic             vec_valid;
  logic             vec_ready;
  logic [N-1:0]     bus_out;
  logic             bus_en;
  logic [A-1:0]     addr;
  logic [7:0]       we;
  logic             busy;
  logic             done;

  modport master (
    output start, count, base_addr, din, vec_valid,
    input  vec_ready, bus_out, bus_en, addr, we, busy, done
  );

  modport slave (
    input  start, count, base_addr, din, vec_valid,
    output vec_ready, bus_out, bus_en, addr, we, busy, done
  );
endinterface

// File: rtl/bus_serializer.sv
// Parallel-to-bus transmitter: accepts N*S-bit vectors and drives them one N-bit word
// per cycle onto the shared tri-state bus, LSB word first, with matching RAM address
// and write strobes. A batch of `count` vectors is written to consecutive words
// starting at `base_addr`. All outputs are decoded from registered state only.
module bus_serializer #(
  parameter int unsigned N = 16,
  parameter int unsigned S = 2,
  parameter int unsigned A = 32
) (
  input logic            clk,
  input logic            rst,
  bus_serializer_if.slave bus
);

  localparam int unsigned WcW = (S > 1) ? $clog2(S) : 1;
  localparam logic [WcW-1:0] WcLast = WcW'(S - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [N*S-1:0]   sreg_q, sreg_d;
  logic [A-1:0]     ptr_q, ptr_d;
  logic [N-1:0]     vcnt_q, vcnt_d;
  logic [WcW-1:0]   wcnt_q, wcnt_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: shift register, address pointer, vector and word counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      ptr_q  <= '0;
      vcnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      sreg_q <= sreg_d;
      ptr_q  <= ptr_d;
      vcnt_q <= vcnt_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Next-state and datapath update; start is honoured only in idle.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    ptr_d   = ptr_q;
    vcnt_d  = vcnt_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          vcnt_d  = bus.count;
          ptr_d   = bus.base_addr;
          state_d = (bus.count == '0) ? StDone : StWait;
        end
      end
      StWait: begin
        if (bus.vec_valid) begin
          sreg_d  = bus.din;
          wcnt_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sreg_d = sreg_q >> N;
        ptr_d  = ptr_q + A'(1);
        wcnt_d = wcnt_q + WcW'(1);
        // Last word of this vector: retire it and either fetch another or finish.
        if (wcnt_q == WcLast) begin
          vcnt_d  = vcnt_q - N'(1);
          state_d = (vcnt_q == N'(1)) ? StDone : StWait;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs; bus_en is confined to the shift state so the bus is never contended.
  always_comb begin
    bus.vec_ready = (state_q == StWait);
    bus.bus_en    = (state_q == StShift);
    bus.bus_out   = (state_q == StShift) ? sreg_q[N-1:0] : '0;
    bus.addr      = ptr_q;
    bus.we        = (state_q == StShift) ? 8'hFF : 8'h00;
    bus.busy      = (state_q != StIdle);
    bus.done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_bus_serializer.sv
// Self-checking bench for bus_serializer (N=16, S=2, A=32). A behavioural model queues
// the expected RAM writes (address, word) per accepted vector; a monitor compares every
// bus cycle against it. Handshake timing is checked cycle by cycle in the driver.
module tb_bus_serializer;

  localparam int unsigned N = 16;
  localparam int unsigned S = 2;
  localparam int unsigned A = 32;

  typedef struct {
    logic [A-1:0] addr;
    logic [N-1:0] data;
  } wr_t;

  logic clk;
  logic rst;

  bus_serializer_if #(.N(N), .S(S), .A(A)) bif ();

  bus_serializer #(.N(N), .S(S), .A(A)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int  n_tests = 0;
  int  n_fail = 0;
  int  done_seen = 0;
  int  exp_done = 0;
  wr_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bus monitor: every driven word must be the next expected write.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ready_and_en", 64'(bif.vec_ready & bif.bus_en), 64'd0);
        if (bif.bus_en) begin
          check("write_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("bus_addr", 64'(bif.addr), 64'(e.addr));
            check("bus_data", 64'(bif.bus_out), 64'(e.data));
          end
          check("we_on", 64'(bif.we), 64'hFF);
        end else begin
          check("we_off", 64'(bif.we), 64'h00);
        end
        if (bif.done) done_seen++;
      end
    end
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Runs one batch starting at a negedge; ends at a negedge with the DUT idle.
  task automatic run_batch(input int cnt, input logic [A-1:0] base, input int stall,
                           input bit rnd_stall, input bit use_fix, input logic [31:0] fix_din,
                           input bit poke);
    logic [31:0] d;
    int          st;
    bif.start     = 1'b1;
    bif.count     = N'(cnt);
    bif.base_addr = base;
    bif.vec_valid = 1'b0;
    @(negedge clk);
    bif.start     = 1'b0;
    bif.count     = N'($urandom);
    bif.base_addr = $urandom;
    if (cnt == 0) begin
      check("zero_done", 64'(bif.done), 64'd1);
      check("zero_ready", 64'(bif.vec_ready), 64'd0);
      check("zero_busy", 64'(bif.busy), 64'd1);
    end else begin
      for (int v = 0; v < cnt; v++) begin
        st = rnd_stall ? int'($urandom_range(0, stall)) : stall;
        bif.vec_valid = 1'b0;
        for (int i = 0; i < st; i++) begin
          check("stall_ready", 64'(bif.vec_ready), 64'd1);
          check("stall_bus_en", 64'(bif.bus_en), 64'd0);
          check("stall_busy", 64'(bif.busy), 64'd1);
          bif.din = $urandom;
          @(negedge clk);
        end
        d = use_fix ? fix_din : $urandom;
        bif.din       = d;
        bif.vec_valid = 1'b1;
        check("accept_ready", 64'(bif.vec_ready), 64'd1);
        for (int k = 0; k < int'(S); k++) begin
          exp_q.push_back('{addr: base + A'(v * int'(S) + k), data: d[N*k +: N]});
        end
        @(negedge clk);
        // Words must appear on the very next cycle and last exactly S cycles.
        for (int k = 0; k < int'(S); k++) begin
          check("shift_en", 64'(bif.bus_en), 64'd1);
          check("shift_ready", 64'(bif.vec_ready), 64'd0);
          check("shift_done", 64'(bif.done), 64'd0);
          bif.din       = $urandom;
          bif.vec_valid = 1'($urandom_range(0, 1));
          if (poke && k == 0) begin
            bif.start     = 1'b1;
            bif.count     = N'(5);
            bif.base_addr = 32'h80;
          end else begin
            bif.start = 1'b0;
          end
          @(negedge clk);
        end
        bif.start = 1'b0;
      end
      bif.vec_valid = 1'b0;
      check("done_pulse", 64'(bif.done), 64'd1);
      check("done_bus_en", 64'(bif.bus_en), 64'd0);
    end
    @(negedge clk);
    check("done_low", 64'(bif.done), 64'd0);
    check("idle_busy", 64'(bif.busy), 64'd0);
    check("drained", 64'(exp_q.size()), 64'd0);
    exp_done++;
  endtask

  initial begin : stimulus
    rst           = 1'b1;
    bif.start     = 1'b0;
    bif.count     = '0;
    bif.base_addr = '0;
    bif.din       = '0;
    bif.vec_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bif.busy), 64'd0);
    check("rst_bus_en", 64'(bif.bus_en), 64'd0);
    check("rst_we", 64'(bif.we), 64'd0);
    check("rst_addr", 64'(bif.addr), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 64'(bif.busy), 64'd0);

    // Single vector with known words at 0x10/0x11.
    run_batch(1, 32'h10, 0, 1'b0, 1'b1, 32'h0002_0001, 1'b0);
    // Three vectors, two stall cycles before each.
    run_batch(3, 32'h10, 2, 1'b0, 1'b0, 32'h0, 1'b0);
    // Zero-length batch.
    run_batch(0, 32'h40, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    // Start pulsed mid-shift must be ignored.
    run_batch(1, 32'h20, 0, 1'b0, 1'b0, 32'h0, 1'b1);
    // Address wrap.
    run_batch(1, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized batches.
    for (int b = 0; b < 15; b++) begin
      logic [A-1:0] base;
      base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - A'($urandom_range(0, 6)))
                                         : A'($urandom);
      run_batch(int'($urandom_range(0, 4)), base, 3, 1'b1, 1'b0, 32'h0,
                1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a shift.
    bif.start     = 1'b1;
    bif.count     = N'(2);
    bif.base_addr = 32'h30;
    @(negedge clk);
    bif.start     = 1'b0;
    bif.din       = 32'hBEEF_CAFE;
    bif.vec_valid = 1'b1;
    exp_q.push_back('{addr: 32'h30, data: 16'hCAFE});
    @(negedge clk);
    bif.vec_valid = 1'b0;
    check("pre_rst_en", 64'(bif.bus_en), 64'd1);
    check("pre_rst_we", 64'(bif.we), 64'hFF);
    #2 rst = 1'b1;
    #1;
    check("async_bus_en", 64'(bif.bus_en), 64'd0);
    check("async_we", 64'(bif.we), 64'd0);
    check("async_busy", 64'(bif.busy), 64'd0);
    check("async_addr", 64'(bif.addr), 64'd0);
    check("async_bus_out", 64'(bif.bus_out), 64'd0);
    check("async_ready", 64'(bif.vec_ready), 64'd0);
    check("async_done", 64'(bif.done), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(bif.busy), 64'd0);
    check("post_rst_en", 64'(bif.bus_en), 64'd0);
    check("post_rst_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    check("post_rst_idle", 64'(bif.busy), 64'd0);
    check("done_count", 64'(done_seen), 64'(exp_done));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
